mem_march_bist: RTL and testbench
=================================

MEM_MARCH_BIST -- requirements
Module: mem_march_bist

Interface
REQ-001 SHALL have parameter Adr_size, default 4, memory address width.
REQ-002 SHALL have parameter Dta_size, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  level; sampled high in IDLE launches a test.
REQ-006 SHALL have port adress  output  Adr_size  memory address.
REQ-007 SHALL have port data  inout  Dta_size  memory data bus.
REQ-008 SHALL have port wr_en  output  1  memory write enable.
REQ-009 SHALL have port read_en  output  1  memory read enable.
REQ-010 SHALL have port busy  output  1  test in progress.
REQ-011 SHALL have port done  output  1  test finished, held until next launch.
REQ-012 SHALL have port fail  output  1  mismatch detected, held until next launch.
REQ-013 SHALL have port fail_adr  output  Adr_size  address of first mismatch.
REQ-014 SHALL have port fail_elem  output  3  March element index (0-5) of first mismatch.
REQ-015 SHALL have port fail_data  output  Dta_size  data read at first mismatch.

Function
REQ-016 SHALL run March C- over all 2^Adr_size words: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0); "0" = all-zeros word, "1" = all-ones word.
REQ-017 SHALL use FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after last op or on first mismatch; DONE->RUN on start=1.
REQ-018 SHALL execute exactly one memory op per clock cycle, back-to-back, no idle cycles inside RUN.
REQ-019 SHALL drive a write cycle as wr_en=1, read_en=0, data=pattern, adress valid for that cycle; memory captures at the closing rising edge.
REQ-020 SHALL drive a read cycle as read_en=1, wr_en=0, data released to Z, and sample data at the rising edge closing that cycle.
REQ-021 SHALL drive data only while wr_en=1; data SHALL be Z in all other cycles and states.
REQ-022 SHALL never assert wr_en and read_en in the same cycle.
REQ-023 SHALL perform each element's ops on one address before advancing; up = 0 to 2^Adr_size-1, down = 2^Adr_size-1 to 0, address counter wrap not used as termination (explicit last-address compare).
REQ-024 SHALL take exactly 10*2^Adr_size RUN cycles (160 for default) for a fault-free memory; first op in the cycle after start is sampled.
REQ-025 SHALL, on mismatch, capture fail_adr, fail_elem, fail_data from the failing read, set fail=1 and done=1, and abort (no further memory ops) in the next cycle.
REQ-026 SHALL assert done=1, busy=0 in the cycle after the final op; busy=1 throughout RUN.
REQ-027 SHALL on launch from DONE clear done, fail, fail_adr, fail_elem, fail_data in the same edge that enters RUN.
REQ-028 SHALL ignore start while in RUN.
REQ-029 SHALL in IDLE and DONE hold wr_en=0, read_en=0, adress=0.

Reset
REQ-030 SHALL on rst_n=0 immediately (asynchronously) force IDLE, wr_en=0, read_en=0, data=Z, adress=0, busy=0, done=0, fail=0, fail_adr=0, fail_elem=0, fail_data=0.
REQ-031 SHALL, if reset asserts mid-RUN, abandon the test without completing the current op; after release, SHALL wait in IDLE for start.

Verification
REQ-032 Fault-free 16x8 memory, start pulse 1 cycle -> 160 op cycles, then done=1, fail=0, busy=0; op sequence matches REQ-016 exactly.
REQ-033 Memory with bit0 of address 5 stuck at 1 -> fail=1, fail_elem=1, fail_adr=5, fail_data=8'h01, no memory op after the failing read.
REQ-034 Memory ignoring writes to address 9 (holds 8'h00) -> fail=1, fail_elem=2, fail_adr=9, fail_data=8'h00.
REQ-035 rst_n low at RUN cycle 50 -> same-cycle wr_en=read_en=0, data=Z, busy=0; after release and start, full 160-cycle pass with done=1, fail=0.
REQ-036 start held high throughout RUN and pulsed again from DONE after a failing run -> mid-run start ignored; relaunch clears fail/capture registers and runs full test.
REQ-037 Bus monitor over all scenarios -> never wr_en=read_en=1; data driven by block only when wr_en=1.

Source files
------------

// File: rtl/mem_march_bist.sv
// March C- memory BIST controller: one memory op per clock, stops at the first
// mismatching read and captures where it happened.
module mem_march_bist #(
  parameter int Adr_size = 4,
  parameter int Dta_size = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [Adr_size-1:0] adress,
  inout  wire  [Dta_size-1:0] data,
  output logic                wr_en,
  output logic                read_en,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [Adr_size-1:0] fail_adr,
  output logic [2:0]          fail_elem,
  output logic [Dta_size-1:0] fail_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [Adr_size-1:0] ADR_LAST = '1;
  localparam logic [Adr_size-1:0] ADR_ONE  = Adr_size'(1);

  state_t              state_q, state_d;
  logic [2:0]          elem_q, elem_d;
  logic [Adr_size-1:0] adr_q, adr_d;
  logic                op_q, op_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [Adr_size-1:0] fail_adr_q, fail_adr_d;
  logic [2:0]          fail_elem_q, fail_elem_d;
  logic [Dta_size-1:0] fail_data_q, fail_data_d;

  logic                down, single_op, elem_end_op, adr_end, mismatch;
  logic [2:0]          elem_nxt;
  logic [Dta_size-1:0] exp_word, wr_word;

  // E1/E3 write ones, E2/E4 expect ones; everything else is the all-zeros word.
  assign down      = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign exp_word  = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
  assign wr_word   = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? '1 : '0;
  assign single_op = (elem_q == 3'd0) || (elem_q == 3'd5);
  assign elem_end_op = single_op || op_q;
  assign adr_end   = down ? (adr_q == '0) : (adr_q == ADR_LAST);
  assign mismatch  = rd_en_q && (data != exp_word);
  assign elem_nxt  = elem_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    adr_d       = adr_q;
    op_d        = op_q;
    wr_en_d     = wr_en_q;
    rd_en_d     = rd_en_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_adr_d  = fail_adr_q;
    fail_elem_d = fail_elem_q;
    fail_data_d = fail_data_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          elem_d      = 3'd0;
          adr_d       = '0;
          op_d        = 1'b0;
          wr_en_d     = 1'b1;
          rd_en_d     = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_adr_d  = '0;
          fail_elem_d = 3'd0;
          fail_data_d = '0;
        end
      end
      RUN: begin
        if (mismatch) begin
          state_d     = DONE;
          wr_en_d     = 1'b0;
          rd_en_d     = 1'b0;
          adr_d       = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          fail_d      = 1'b1;
          fail_adr_d  = adr_q;
          fail_elem_d = elem_q;
          fail_data_d = data;
        end else if (!elem_end_op) begin
          // second op of a two-op element is always the write
          op_d    = 1'b1;
          wr_en_d = 1'b1;
          rd_en_d = 1'b0;
        end else if (!adr_end) begin
          adr_d   = down ? (adr_q - ADR_ONE) : (adr_q + ADR_ONE);
          op_d    = 1'b0;
          wr_en_d = (elem_q == 3'd0);
          rd_en_d = (elem_q != 3'd0);
        end else if (elem_q == 3'd5) begin
          state_d = DONE;
          wr_en_d = 1'b0;
          rd_en_d = 1'b0;
          adr_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          elem_d  = elem_nxt;
          adr_d   = ((elem_nxt == 3'd3) || (elem_nxt == 3'd4)) ? ADR_LAST : '0;
          op_d    = 1'b0;
          wr_en_d = 1'b0;
          rd_en_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      elem_q      <= 3'd0;
      adr_q       <= '0;
      op_q        <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_adr_q  <= '0;
      fail_elem_q <= 3'd0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      adr_q       <= adr_d;
      op_q        <= op_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_adr_q  <= fail_adr_d;
      fail_elem_q <= fail_elem_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign data      = wr_en_q ? wr_word : {Dta_size{1'bz}};
  assign adress    = adr_q;
  assign wr_en     = wr_en_q;
  assign read_en   = rd_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_adr  = fail_adr_q;
  assign fail_elem = fail_elem_q;
  assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mem_march_bist.sv
// Directed bench for mem_march_bist: behavioural 16x8 memory with injectable
// faults, cycle-by-cycle comparison against a March C- op list.
module tb_mem_march_bist;

  localparam logic [7:0] PROBE = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] adress;
  wire  [7:0] data;
  logic       wr_en, read_en, busy, done, fail;
  logic [3:0] fail_adr;
  logic [2:0] fail_elem;
  logic [7:0] fail_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mem [16];
  logic [7:0] rd_val;
  int         fault_mode = 0;
  logic       init_mem = 1'b0;

  bit         exp_wr  [160];
  logic [3:0] exp_adr [160];
  logic [7:0] exp_dat [160];
  int         n_ops = 0;

  mem_march_bist #(.Adr_size(4), .Dta_size(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .adress(adress), .data(data),
    .wr_en(wr_en), .read_en(read_en), .busy(busy), .done(done), .fail(fail),
    .fail_adr(fail_adr), .fail_elem(fail_elem), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  // Memory drives on reads; a probe value keeps the bus defined when idle so
  // any stray drive from the BIST shows up as a changed value.
  always_comb rd_val = mem[adress] | ((fault_mode == 1 && adress == 4'd5) ? 8'h01 : 8'h00);
  assign data = read_en ? rd_val : (wr_en ? 8'hzz : PROBE);

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (wr_en && !(fault_mode == 2 && adress == 4'd9)) begin
      mem[adress] <= data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    check("mon_excl", {31'd0, wr_en & read_en}, 32'd0);
    if (!wr_en && !read_en) check("mon_bus_idle", {24'd0, data}, {24'd0, PROBE});
  end

  task automatic push(input bit w, input int a, input logic [7:0] d);
    exp_wr[n_ops]  = w;
    exp_adr[n_ops] = 4'(a);
    exp_dat[n_ops] = d;
    n_ops++;
  endtask

  task automatic check_op(input int i);
    check("op_wr",  {31'd0, wr_en},   {31'd0, exp_wr[i]});
    check("op_rd",  {31'd0, read_en}, {31'd0, !exp_wr[i]});
    check("op_adr", {28'd0, adress},  {28'd0, exp_adr[i]});
    check("op_busy", {31'd0, busy}, 32'd1);
    if (exp_wr[i]) check("op_wdata", {24'd0, data}, {24'd0, exp_dat[i]});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr"},  {31'd0, wr_en},   32'd0);
    check({tag, "_rd"},  {31'd0, read_en}, 32'd0);
    check({tag, "_adr"}, {28'd0, adress},  32'd0);
    check({tag, "_busy"}, {31'd0, busy},   32'd0);
  endtask

  task automatic run(input int fault, input int n_exp, input bit hold,
                     input bit e_fail, input logic [3:0] e_adr,
                     input logic [2:0] e_elem, input logic [7:0] e_data);
    @(negedge clk);
    init_mem = 1'b1;
    fault_mode = fault;
    @(negedge clk);
    init_mem = 1'b0;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check("launch_done", {31'd0, done}, 32'd0);
    check("launch_fail", {31'd0, fail}, 32'd0);
    check("launch_fadr", {28'd0, fail_adr}, 32'd0);
    check("launch_felem", {29'd0, fail_elem}, 32'd0);
    check("launch_fdata", {24'd0, fail_data}, 32'd0);
    for (int i = 0; i < n_exp; i++) begin
      if (i > 0) @(negedge clk);
      check_op(i);
    end
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk);
      check_idle_outputs("end");
      check("end_done", {31'd0, done}, 32'd1);
      check("end_fail", {31'd0, fail}, {31'd0, e_fail});
      check("end_fadr", {28'd0, fail_adr}, {28'd0, e_adr});
      check("end_felem", {29'd0, fail_elem}, {29'd0, e_elem});
      check("end_fdata", {24'd0, fail_data}, {24'd0, e_data});
    end
  endtask

  initial begin
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 16; k++) begin
        int a;
        a = (e == 3 || e == 4) ? 15 - k : k;
        case (e)
          0: push(1'b1, a, 8'h00);
          1: begin push(1'b0, a, 8'h00); push(1'b1, a, 8'hFF); end
          2: begin push(1'b0, a, 8'hFF); push(1'b1, a, 8'h00); end
          3: begin push(1'b0, a, 8'h00); push(1'b1, a, 8'hFF); end
          4: begin push(1'b0, a, 8'hFF); push(1'b1, a, 8'h00); end
          default: push(1'b0, a, 8'h00);
        endcase
      end
    end

    #2;
    check_idle_outputs("rst");
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fail", {31'd0, fail}, 32'd0);
    check("rst_fadr", {28'd0, fail_adr}, 32'd0);
    check("rst_felem", {29'd0, fail_elem}, 32'd0);
    check("rst_fdata", {24'd0, fail_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");

    run(0, 160, 1'b0, 1'b0, 4'd0, 3'd0, 8'h00);
    run(1, 27,  1'b0, 1'b1, 4'd5, 3'd1, 8'h01);
    run(2, 67,  1'b0, 1'b1, 4'd9, 3'd2, 8'h00);

    // reset during op 50 of a fault-free run
    @(negedge clk);
    init_mem = 1'b1;
    fault_mode = 0;
    @(negedge clk);
    init_mem = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i > 0) @(negedge clk);
      check_op(i);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    check("midrst_bus", {24'd0, data}, {24'd0, PROBE});
    check("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle_outputs("postrst");
      check("postrst_done", {31'd0, done}, 32'd0);
    end
    run(0, 160, 1'b0, 1'b0, 4'd0, 3'd0, 8'h00);

    // start held through a failing run, then relaunch clean from DONE
    run(1, 27,  1'b1, 1'b1, 4'd5, 3'd1, 8'h01);
    run(0, 160, 1'b0, 1'b0, 4'd0, 3'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
